// File: rtl/cpu_ce_governor_if.sv
// Control/status bundle between the CPU clock-enable governor and the board top.
// The governor sits on the slave side; the board top (or a bench) drives the master side.
interface cpu_ce_governor_if #(
  parameter int NUM_STALL = 2,
  parameter int DEBT_W    = 16
);
  logic [NUM_STALL-1:0] stall_rdy;
  logic                 turbo;
  logic                 pause_rq;
  logic                 vsync;
  logic                 debt_clear;
  logic                 ce_base;
  logic                 ce_cpu;
  logic                 paused;
  logic [DEBT_W-1:0]    debt;
  logic                 debt_ovf;

  modport master (
    output stall_rdy, turbo, pause_rq, vsync, debt_clear,
    input  ce_base, ce_cpu, paused, debt, debt_ovf
  );

  modport slave (
    input  stall_rdy, turbo, pause_rq, vsync, debt_clear,
    output ce_base, ce_cpu, paused, debt, debt_ovf
  );
endinterface

// File: rtl/cpu_ce_governor.sv
// Fractional CPU clock-enable generator: base rate CEN_N/CEN_M, stall debt with
// back-to-back catch-up repayment, frame-aligned pause and turbo.
module cpu_ce_governor #(
  parameter int CEN_N      = 9,
  parameter int CEN_M      = 20,
  parameter int NUM_STALL  = 2,
  parameter int DEBT_W     = 16,
  parameter int DEBT_MAX   = 65535,
  parameter int CATCHUP_EN = 1
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  cpu_ce_governor_if.slave bus
);

  localparam int ACC_W = $clog2(CEN_M) + 1;
  localparam logic [ACC_W:0]    N_EXT    = (ACC_W+1)'(CEN_N);
  localparam logic [ACC_W:0]    M_EXT    = (ACC_W+1)'(CEN_M);
  localparam logic [DEBT_W-1:0] DEBT_TOP = DEBT_W'(DEBT_MAX);
  localparam logic              CATCHUP  = (CATCHUP_EN != 0);

  typedef enum logic {RUN, PAUSE} state_e;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W:0]    acc_sum;
  logic              tick;
  logic              rdy;
  logic              ce_cpu;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovf_q, ovf_d;
  state_e            state_q;
  logic              paused_q;

  // One spare bit in the sum so acc+CEN_N never wraps before the compare.
  always_comb begin
    acc_sum = {1'b0, acc_q} + N_EXT;
    tick    = (acc_sum >= M_EXT);
    acc_d   = tick ? ACC_W'(acc_sum - M_EXT) : acc_sum[ACC_W-1:0];
  end

  assign rdy    = &bus.stall_rdy;
  assign ce_cpu = reset_n & ~paused_q & rdy &
                  (tick | bus.turbo | (CATCHUP & (debt_q != '0)));

  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (bus.debt_clear) begin
      debt_d = '0;
      ovf_d  = 1'b0;
    end else if (paused_q) begin
      debt_d = debt_q;
    end else if (tick & ~rdy) begin
      if (debt_q == DEBT_TOP) ovf_d  = 1'b1;
      else                    debt_d = debt_q + 1'b1;
    end else if (ce_cpu & ~tick & ~bus.turbo & (debt_q != '0)) begin
      debt_d = debt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Pause only enters on a frame boundary and only leaves once vsync has dropped.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      paused_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.pause_rq & bus.vsync) begin
            state_q  <= PAUSE;
            paused_q <= 1'b1;
          end
        end
        PAUSE: begin
          if (~bus.pause_rq & ~bus.vsync) begin
            state_q  <= RUN;
            paused_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          paused_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ce_base  = reset_n & tick;
  assign bus.ce_cpu   = ce_cpu;
  assign bus.paused   = paused_q;
  assign bus.debt     = debt_q;
  assign bus.debt_ovf = ovf_q;

endmodule

// File: tb/tb_cpu_ce_governor.sv
// Directed bench for cpu_ce_governor: default, small-saturation and no-catch-up instances.
module tb_cpu_ce_governor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_ce_governor_if #(.NUM_STALL(2), .DEBT_W(16)) if_a ();
  cpu_ce_governor_if #(.NUM_STALL(2), .DEBT_W(16)) if_b ();
  cpu_ce_governor_if #(.NUM_STALL(2), .DEBT_W(16)) if_c ();

  cpu_ce_governor dut_a (.clk_sys(clk), .reset_n(rst_n), .bus(if_a.slave));
  cpu_ce_governor #(.DEBT_MAX(3)) dut_b (.clk_sys(clk), .reset_n(rst_n), .bus(if_b.slave));
  cpu_ce_governor #(.CATCHUP_EN(0)) dut_c (.clk_sys(clk), .reset_n(rst_n), .bus(if_c.slave));

  int total = 0;
  int passed = 0;
  int cnt;
  logic [19:0] base_pat = 20'hAA954;  // ticks at 2,4,6,8,11,13,15,17,19

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_a.stall_rdy = 2'b11; if_a.turbo = 0; if_a.pause_rq = 0; if_a.vsync = 0; if_a.debt_clear = 0;
    if_b.stall_rdy = 2'b11; if_b.turbo = 0; if_b.pause_rq = 0; if_b.vsync = 0; if_b.debt_clear = 0;
    if_c.stall_rdy = 2'b11; if_c.turbo = 0; if_c.pause_rq = 0; if_c.vsync = 0; if_c.debt_clear = 0;
  endtask

  // Leaves the bench at cycle 0 (acc=0), just after reset release.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, with turbo asserted to show ce_cpu is held low in reset
    idle_inputs();
    if_a.turbo = 1'b1;
    next_cycle();
    #1;
    chk("rst_ce_base", if_a.ce_base, 0);
    chk("rst_ce_cpu", if_a.ce_cpu, 0);
    chk("rst_paused", if_a.paused, 0);
    chk("rst_debt", if_a.debt, 0);
    chk("rst_ovf", if_a.debt_ovf, 0);

    // 1: base pattern, ce_cpu follows ce_base
    do_reset();
    for (int c = 0; c < 40; c++) begin
      #1;
      chk($sformatf("t1_base_c%0d", c), if_a.ce_base, base_pat[c % 20]);
      chk($sformatf("t1_cpu_c%0d", c), if_a.ce_cpu, base_pat[c % 20]);
      next_cycle();
    end

    // 2: 40-cycle stall, then catch-up
    do_reset();
    if_a.stall_rdy = 2'b01;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      cnt += int'(if_a.ce_cpu);
      next_cycle();
    end
    #1;
    chk("t2_stall_cpu_cnt", cnt, 0);
    chk("t2_debt_18", if_a.debt, 18);
    if_a.stall_rdy = 2'b11;
    cnt = 0;
    for (int c = 40; c <= 70; c++) begin
      #1;
      if (c == 43) chk("t2_debt_c43", if_a.debt, 16);
      if (c == 60) chk("t2_debt_c60", if_a.debt, 7);
      cnt += int'(if_a.ce_cpu);
      next_cycle();
    end
    #1;
    chk("t2_repay_cnt", cnt, 31);
    chk("t2_debt_zero", if_a.debt, 0);
    cnt = 0;
    for (int c = 71; c <= 90; c++) begin
      #1;
      cnt += int'(if_a.ce_cpu);
      next_cycle();
    end
    #1;
    chk("t2_rate_after", cnt, 9);
    chk("t2_debt_after", if_a.debt, 0);

    // 3: saturation at DEBT_MAX=3, clear, clear beats a stalled tick
    do_reset();
    if_b.stall_rdy = 2'b01;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 7) begin
        chk("t3_debt_c7", if_b.debt, 3);
        chk("t3_ovf_c7", if_b.debt_ovf, 0);
      end
      if (c == 9) begin
        chk("t3_debt_c9", if_b.debt, 3);
        chk("t3_ovf_c9", if_b.debt_ovf, 1);
      end
      next_cycle();
    end
    if_b.debt_clear = 1'b1;
    next_cycle();
    if_b.debt_clear = 1'b0;
    #1;
    chk("t3_clr_debt", if_b.debt, 0);
    chk("t3_clr_ovf", if_b.debt_ovf, 0);
    next_cycle();
    if_b.debt_clear = 1'b1;
    #1;
    chk("t3_tick_c22", if_b.ce_base, 1);
    next_cycle();
    if_b.debt_clear = 1'b0;
    #1;
    chk("t3_clr_wins", if_b.debt, 0);
    next_cycle();
    next_cycle();
    #1;
    chk("t3_inc_again", if_b.debt, 1);

    // 4: frame-aligned pause
    do_reset();
    if_a.stall_rdy = 2'b01;
    for (int c = 0; c < 5; c++) next_cycle();
    if_a.pause_rq = 1'b1;
    #1;
    chk("t4_no_vsync_paused", if_a.paused, 0);
    chk("t4_stalled_cpu", if_a.ce_cpu, 0);
    next_cycle();
    if_a.vsync = 1'b1;
    #1;
    chk("t4_vsync_paused", if_a.paused, 0);
    next_cycle();
    if_a.vsync = 1'b0;
    if_a.stall_rdy = 2'b11;
    #1;
    chk("t4_paused", if_a.paused, 1);
    chk("t4_paused_cpu", if_a.ce_cpu, 0);
    chk("t4_debt_c7", if_a.debt, 3);
    next_cycle();
    if_a.stall_rdy = 2'b01;
    #1;
    chk("t4_base_runs", if_a.ce_base, 1);
    next_cycle();
    #1;
    chk("t4_debt_frozen", if_a.debt, 3);
    if_a.pause_rq = 1'b0;
    if_a.vsync = 1'b1;
    next_cycle();
    #1;
    chk("t4_hold_c10", if_a.paused, 1);
    next_cycle();
    if_a.vsync = 1'b0;
    #1;
    chk("t4_hold_c11", if_a.paused, 1);
    next_cycle();
    if_a.stall_rdy = 2'b11;
    #1;
    chk("t4_released", if_a.paused, 0);
    chk("t4_debt_c12", if_a.debt, 3);
    chk("t4_repay_cpu", if_a.ce_cpu, 1);
    next_cycle();
    #1;
    chk("t4_debt_c13", if_a.debt, 2);

    // 5: turbo does not consume debt; async reset mid-catch-up
    do_reset();
    if_a.stall_rdy = 2'b01;
    for (int c = 0; c < 12; c++) next_cycle();
    if_a.stall_rdy = 2'b11;
    if_a.turbo = 1'b1;
    #1;
    chk("t5_debt_5", if_a.debt, 5);
    cnt = 0;
    for (int c = 12; c < 32; c++) begin
      #1;
      cnt += int'(if_a.ce_cpu);
      next_cycle();
    end
    #1;
    chk("t5_turbo_cnt", cnt, 20);
    chk("t5_turbo_debt", if_a.debt, 5);
    if_a.turbo = 1'b0;
    #1;
    chk("t5_repay_cpu", if_a.ce_cpu, 1);
    next_cycle();
    #1;
    chk("t5_debt_4", if_a.debt, 4);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cpu", if_a.ce_cpu, 0);
    chk("t5_rst_debt", if_a.debt, 0);
    chk("t5_rst_base", if_a.ce_base, 0);

    // 6: catch-up disabled
    do_reset();
    if_c.stall_rdy = 2'b01;
    for (int c = 0; c < 20; c++) next_cycle();
    if_c.stall_rdy = 2'b11;
    #1;
    chk("t6_debt_9", if_c.debt, 9);
    chk("t6_no_catchup_cpu", if_c.ce_cpu, 0);
    cnt = 0;
    for (int c = 20; c < 40; c++) begin
      #1;
      cnt += int'(if_c.ce_cpu);
      next_cycle();
    end
    #1;
    chk("t6_rate", cnt, 9);
    chk("t6_debt_kept", if_c.debt, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
